// File: rtl/prev_test_core.sv
// prev_test_core: first-difference stage for a signed sample stream.
// Registers the last sample (prev) and the difference x - prev (diff).
// There is no handshake: one sample is taken on every rising edge of clk,
// and both outputs are valid one clock after their sample.
// Optional feature macro: PREV_TEST_SAT_EN. When it is defined, diff
// saturates on overflow. When it is undefined, diff wraps modulo 2^WIDTH.
module prev_test_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] prev,
    output logic [WIDTH-1:0] diff
);

    // Raw WIDTH-bit difference against the registered previous sample.
    logic [WIDTH-1:0] raw_diff;
    logic [WIDTH-1:0] next_diff;

`ifdef PREV_TEST_SAT_EN
    logic             ovf;
    logic [WIDTH-1:0] sat_max;
    logic [WIDTH-1:0] sat_min;
`endif

    // Subtract, then optionally clamp when the signed result leaves the range.
    always_comb begin
        raw_diff  = x - prev;
        next_diff = raw_diff;
`ifdef PREV_TEST_SAT_EN
        sat_max = {1'b0, {(WIDTH-1){1'b1}}};
        sat_min = {1'b1, {(WIDTH-1){1'b0}}};
        // Overflow is possible only when the operands have opposite signs.
        // It has occurred when the result sign differs from the sign of x.
        ovf = (x[WIDTH-1] != prev[WIDTH-1]) && (raw_diff[WIDTH-1] != x[WIDTH-1]);
        if (ovf) begin
            next_diff = x[WIDTH-1] ? sat_min : sat_max;
        end
`endif
    end

    // Both outputs are registered. Reset takes priority over sampling x.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            diff <= '0;
        end else begin
            prev <= x;
            diff <= next_diff;
        end
    end

endmodule

// File: tb/tb_prev_test_core.sv
// Testbench for prev_test_core (WIDTH=32).
// The driver pushes the expected {prev, diff} for each edge into exp_q.
// The monitor pops one entry after each edge and compares it with the outputs.
module tb_prev_test_core;

  localparam int W = 32;
  localparam logic [W-1:0] MAXV = 32'h7fff_ffff;
  localparam logic [W-1:0] MINV = 32'h8000_0000;

  logic         clk;
  logic         rst;
  logic [W-1:0] x;
  logic [W-1:0] prev;
  logic [W-1:0] diff;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   model_prev;
  int             checks;
  int             errors;
  bit             done;

  prev_test_core #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .x    (x),
    .prev (prev),
    .diff (diff)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Queue one edge with hand-computed expected outputs.
  task automatic drive(input logic r, input logic [W-1:0] xv,
                       input logic [W-1:0] ep, input logic [W-1:0] ed);
    @(negedge clk);
    rst = r;
    x   = xv;
    exp_q.push_back({ep, ed});
    model_prev = r ? '0 : xv;
  endtask

  // Compute the reference difference with wide arithmetic.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] xv, input logic [W-1:0] pv);
    longint d;
    d = longint'($signed(xv)) - longint'($signed(pv));
`ifdef PREV_TEST_SAT_EN
    if (d > longint'($signed(MAXV))) return MAXV;
    if (d < longint'($signed(MINV))) return MINV;
`endif
    return d[W-1:0];
  endfunction

  // Queue one random sample. The expected outputs come from the model.
  task automatic drive_rand();
    logic [W-1:0] xv;
    xv = $urandom();
    case ($urandom_range(0, 7))
      0: xv = MAXV;
      1: xv = MINV;
      2: xv = '1;
      3: xv = 32'd1;
      default: ;
    endcase
    drive(1'b0, xv, xv, ref_diff(xv, model_prev));
  endtask

  // Monitor: after each edge, compare the outputs with the oldest expected entry.
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (prev !== e[2*W-1:W]) begin
          errors++;
          $display("FAIL prev: got %0d expected %0d", $signed(prev), $signed(e[2*W-1:W]));
        end
        checks++;
        if (diff !== e[W-1:0]) begin
          errors++;
          $display("FAIL diff: got %0d expected %0d", $signed(diff), $signed(e[W-1:0]));
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int wait_cnt;
    rst = 1'b1;
    x = 32'd123;
    model_prev = '0;
    checks = 0;
    errors = 0;
    done = 1'b0;

    // Reset with x=123, then release with x=0.
    drive(1'b1, 32'd123, 32'd0, 32'd0);
    drive(1'b1, 32'd123, 32'd0, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 32'd0);

    // Basic stream.
    drive(1'b1, 32'd0, 32'd0, 32'd0);
    drive(1'b0, 32'd10, 32'd10, 32'd10);
    drive(1'b0, -32'sd5, -32'sd5, -32'sd15);
    drive(1'b0, 32'd20, 32'd20, 32'd25);

    // Constant input after reset.
    drive(1'b1, 32'd0, 32'd0, 32'd0);
    drive(1'b0, 32'd7, 32'd7, 32'd7);
    drive(1'b0, 32'd7, 32'd7, 32'd0);
    drive(1'b0, 32'd7, 32'd7, 32'd0);
    drive(1'b0, 32'd7, 32'd7, 32'd0);

    // Overflow: prev=1, then x=min.
    drive(1'b0, 32'd1, 32'd1, -32'sd6);
`ifdef PREV_TEST_SAT_EN
    drive(1'b0, MINV, MINV, MINV);
`else
    drive(1'b0, MINV, MINV, MAXV);
`endif
    // Overflow: prev=-1, then x=max.
    drive(1'b0, -32'sd1, -32'sd1, MAXV);
`ifdef PREV_TEST_SAT_EN
    drive(1'b0, MAXV, MAXV, MAXV);
`else
    drive(1'b0, MAXV, MAXV, MINV);
`endif

    // Mid-stream reset.
    drive(1'b1, 32'd0, 32'd0, 32'd0);
    drive(1'b0, 32'd50, 32'd50, 32'd50);
    drive(1'b0, 32'd60, 32'd60, 32'd10);
    drive(1'b1, 32'd70, 32'd0, 32'd0);
    drive(1'b0, 32'd5, 32'd5, 32'd5);

    // Random stream checked against the wide-arithmetic model.
    for (int i = 0; i < 10000; i++) begin
      drive_rand();
    end

    // Wait for the monitor to drain the queue, within a cycle budget.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    done = 1'b1;
    $finish;
  end

endmodule
